// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the five-stage MIPS pipeline.
// Holds the fetch PC and drives the instruction memory, which it reads combinationally.
// It latches the fetched word and its PC into IF/ID. It supports stall and redirect,
// and a redirect squashes the wrong-path word.
//
// Ports:
//   clk             - single clock, all state updates on the rising edge
//   reset           - synchronous active-high reset
//   stall           - hold pc, IF/ID and fetch_count this cycle
//   redirect_en     - load redirect_target into pc and bubble IF/ID (beats stall)
//   redirect_target - new pc, low two bits forced to zero
//   imem_addr       - instruction-memory address (combinationally equal to pc)
//   imem_rdata      - instruction word at imem_addr, valid in the same cycle
//   pc              - current fetch pc
//   id_instr        - instruction presented to decode, zero for a bubble
//   id_pc           - pc of id_instr
//   id_pc_plus4     - id_pc + 4
//   id_valid        - id_instr is a real fetched instruction
//   fetch_count     - valid instructions delivered to IF/ID since reset
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);
  localparam logic [XLEN-1:0] NOP         = '0;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] count_q;
  ifid_t           ifid_q;

  logic [XLEN-1:0] pc_plus4_c;
  logic [XLEN-1:0] target_c;

  // Sequential pc increment (wraps modulo 2^32) and the word-aligned redirect target
  always_comb begin
    pc_plus4_c = pc_q + INSTR_BYTES;
    target_c   = redirect_target & ALIGN_MASK;
  end

  // pc register: reset > redirect > stall > advance
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (redirect_en) begin
      pc_q <= target_c;
    end else if (!stall) begin
      pc_q <= pc_plus4_c;
    end
  end

  // IF/ID register: on a redirect the word fetched this cycle is squashed.
  // The id pc fields keep their old values, so only instr and valid change.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_q <= '0;
    end else if (redirect_en) begin
      ifid_q.instr <= NOP;
      ifid_q.valid <= 1'b0;
    end else if (!stall) begin
      ifid_q.instr    <= imem_rdata;
      ifid_q.pc       <= pc_q;
      ifid_q.pc_plus4 <= pc_plus4_c;
      ifid_q.valid    <= 1'b1;
    end
  end

  // Count of valid instructions loaded into IF/ID
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (!redirect_en && !stall) begin
      count_q <= count_q + XLEN'(1);
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign id_instr    = ifid_q.instr;
  assign id_pc       = ifid_q.pc;
  assign id_pc_plus4 = ifid_q.pc_plus4;
  assign id_valid    = ifid_q.valid;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. The instruction memory returns word = address.
// Every normal fetch pushes its expected IF/ID entry into a scoreboard queue.
// The entry is popped and compared when the word appears on id_*.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic [31:0] fetch_count;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] m_pc;
  int          passed = 0;
  int          total  = 0;

  fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_en(redirect_en),
    .redirect_target(redirect_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc(pc), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .id_valid(id_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr;

  // Advance one clock, tracking the fetch pc and pushing expected IF/ID entries.
  task automatic cycle();
    if (reset) begin
      m_pc = 32'h0000_3000;
      sb.delete();
    end else if (redirect_en) begin
      m_pc = {redirect_target[31:2], 2'b00};
    end else if (!stall) begin
      sb.push_back('{instr: m_pc, pc: m_pc, pc_plus4: m_pc + 32'd4});
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_target = '0;
    cycle();
    cycle();
    reset = 1'b0;
    total++; if (pc !== 32'h3000) $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); else passed++;
    total++; if (imem_addr !== 32'h3000) $display("FAIL reset_imem_addr got=%h exp=%h", imem_addr, 32'h3000); else passed++;
    total++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid got=%b exp=0", id_valid); else passed++;
    total++; if (id_instr !== 32'h0) $display("FAIL reset_id_instr got=%h exp=0", id_instr); else passed++;
    total++; if (id_pc !== 32'h0) $display("FAIL reset_id_pc got=%h exp=0", id_pc); else passed++;
    total++; if (fetch_count !== 32'd0) $display("FAIL reset_count got=%0d exp=0", fetch_count); else passed++;
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 2; i++) begin
      cycle();
      total++;
      if (sb.size() == 0) $display("FAIL run_sb_empty cycle=%0d", i);
      else begin
        e = sb.pop_front();
        if (id_instr !== e.instr || id_pc !== e.pc || id_pc_plus4 !== e.pc_plus4 || id_valid !== 1'b1)
          $display("FAIL run_ifid got=%h/%h/%h/%b exp=%h/%h/%h/1", id_instr, id_pc, id_pc_plus4, id_valid,
                   e.instr, e.pc, e.pc_plus4);
        else passed++;
      end
      total++; if (id_pc !== 32'h3000 + 32'(4 * i)) $display("FAIL run_id_pc got=%h exp=%h", id_pc, 32'h3000 + 32'(4 * i)); else passed++;
      total++; if (fetch_count !== 32'(i + 1)) $display("FAIL run_count got=%0d exp=%0d", fetch_count, i + 1); else passed++;
    end
    total++; if (pc !== 32'h3008) $display("FAIL run_pc got=%h exp=%h", pc, 32'h3008); else passed++;
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (pc !== 32'h3008 || id_instr !== 32'h3004 || id_valid !== 1'b1 || fetch_count !== 32'd2)
        $display("FAIL stall_hold cycle=%0d got pc=%h instr=%h v=%b cnt=%0d exp pc=3008 instr=3004 v=1 cnt=2",
                 i, pc, id_instr, id_valid, fetch_count);
      else passed++;
    end
    stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      total++;
      if (sb.size() == 0) $display("FAIL resume_sb_empty cycle=%0d", i);
      else begin
        e = sb.pop_front();
        if (id_instr !== e.instr || id_pc !== e.pc || id_valid !== 1'b1)
          $display("FAIL resume_ifid got=%h/%h/%b exp=%h/%h/1", id_instr, id_pc, id_valid, e.instr, e.pc);
        else passed++;
      end
    end
    total++; if (id_instr !== 32'h300C) $display("FAIL resume_instr got=%h exp=%h", id_instr, 32'h300C); else passed++;
    total++; if (fetch_count !== 32'd4) $display("FAIL resume_count got=%0d exp=4", fetch_count); else passed++;
    total++; if (pc !== 32'h3010) $display("FAIL resume_pc got=%h exp=%h", pc, 32'h3010); else passed++;
  endtask

  task automatic test_redirect();
    redirect_en = 1'b1; redirect_target = 32'h3041;
    cycle();
    redirect_en = 1'b0;
    total++; if (pc !== 32'h3040) $display("FAIL redir_pc got=%h exp=%h", pc, 32'h3040); else passed++;
    total++;
    if (id_valid !== 1'b0 || id_instr !== 32'h0) $display("FAIL redir_bubble got=%h/%b exp=0/0", id_instr, id_valid);
    else passed++;
    total++;
    if (id_pc !== 32'h300C || id_pc_plus4 !== 32'h3010)
      $display("FAIL redir_pc_hold got=%h/%h exp=300c/3010", id_pc, id_pc_plus4);
    else passed++;
    total++; if (fetch_count !== 32'd4) $display("FAIL redir_count got=%0d exp=4", fetch_count); else passed++;
    cycle();
    total++;
    if (sb.size() == 0) $display("FAIL redir_sb_empty");
    else begin
      e = sb.pop_front();
      if (id_instr !== e.instr || id_pc !== e.pc || id_valid !== 1'b1)
        $display("FAIL redir_target_ifid got=%h/%h/%b exp=%h/%h/1", id_instr, id_pc, id_valid, e.instr, e.pc);
      else passed++;
    end
    total++; if (id_instr !== 32'h3040) $display("FAIL redir_target_instr got=%h exp=%h", id_instr, 32'h3040); else passed++;
    total++; if (fetch_count !== 32'd5) $display("FAIL redir_target_count got=%0d exp=5", fetch_count); else passed++;
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1; redirect_en = 1'b1; redirect_target = 32'h3100;
    cycle();
    stall = 1'b0; redirect_en = 1'b0;
    total++; if (pc !== 32'h3100) $display("FAIL sr_pc got=%h exp=%h", pc, 32'h3100); else passed++;
    total++;
    if (id_valid !== 1'b0 || id_instr !== 32'h0) $display("FAIL sr_bubble got=%h/%b exp=0/0", id_instr, id_valid);
    else passed++;
    total++; if (fetch_count !== 32'd5) $display("FAIL sr_count got=%0d exp=5", fetch_count); else passed++;
  endtask

  task automatic test_wrap();
    redirect_en = 1'b1; redirect_target = 32'hFFFF_FFFE;
    cycle();
    redirect_en = 1'b0;
    total++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc0 got=%h exp=fffffffc", pc); else passed++;
    cycle();
    total++; if (pc !== 32'h0) $display("FAIL wrap_pc got=%h exp=0", pc); else passed++;
    total++;
    if (sb.size() == 0) $display("FAIL wrap_sb_empty");
    else begin
      e = sb.pop_front();
      if (id_instr !== e.instr || id_pc !== e.pc || id_pc_plus4 !== e.pc_plus4)
        $display("FAIL wrap_ifid got=%h/%h/%h exp=%h/%h/%h", id_instr, id_pc, id_pc_plus4, e.instr, e.pc, e.pc_plus4);
      else passed++;
    end
    total++;
    if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0)
      $display("FAIL wrap_id_pc got=%h/%h exp=fffffffc/0", id_pc, id_pc_plus4);
    else passed++;
    total++; if (fetch_count !== 32'd6) $display("FAIL wrap_count got=%0d exp=6", fetch_count); else passed++;
  endtask

  task automatic test_reset_during_stall();
    redirect_en = 1'b1; redirect_target = 32'h3020;
    cycle();
    redirect_en = 1'b0;
    total++; if (pc !== 32'h3020) $display("FAIL rst_setup_pc got=%h exp=3020", pc); else passed++;
    stall = 1'b1; reset = 1'b1;
    cycle();
    reset = 1'b0; stall = 1'b0;
    total++; if (pc !== 32'h3000) $display("FAIL rst_stall_pc got=%h exp=3000", pc); else passed++;
    total++;
    if (id_valid !== 1'b0 || fetch_count !== 32'd0)
      $display("FAIL rst_stall_state got=%b/%0d exp=0/0", id_valid, fetch_count);
    else passed++;
    cycle();
    total++;
    if (id_valid !== 1'b1 || id_instr !== 32'h3000 || fetch_count !== 32'd1)
      $display("FAIL rst_first_fetch got=%b/%h/%0d exp=1/3000/1", id_valid, id_instr, fetch_count);
    else passed++;
    total++;
    if (sb.size() == 0) $display("FAIL rst_sb_empty");
    else begin
      e = sb.pop_front();
      if (id_pc !== e.pc || id_pc_plus4 !== e.pc_plus4)
        $display("FAIL rst_first_pc got=%h/%h exp=%h/%h", id_pc, id_pc_plus4, e.pc, e.pc_plus4);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      stall = (i == 2);
      cycle();
    end
    stall = 1'b0;
    total++; if (fetch_count !== 32'd6) $display("FAIL b2b_count got=%0d exp=6", fetch_count); else passed++;
    total++; if (pc !== 32'h3018) $display("FAIL b2b_pc got=%h exp=3018", pc); else passed++;
  endtask

  initial begin
    m_pc = 32'h0000_3000;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_wrap();
    test_reset_during_stall();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS pipeline. Holds the program counter and drives the instruction-memory address. Latches the fetched word plus its PC into the IF/ID register that feeds the decode stage. Supports stall (hold) and redirect (branch/jump target from decode), with squash of the wrong-path instruction.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and IF/ID contents this cycle.
- redirect_en  input  1  decode resolved a taken branch/J/JAL/JR; load redirect_target.
- redirect_target  input  32  new PC; bits [1:0] ignored, forced to 0.
- imem_addr  output  32  instruction-memory address; combinationally equal to pc.
- imem_rdata  input  32  instruction word at imem_addr, valid in the same cycle (combinational read).
- pc  output  32  current fetch PC.
- id_instr  output  32  instruction presented to decode; 32'h0000_0000 (NOP) when bubble.
- id_pc  output  32  PC of id_instr.
- id_pc_plus4  output  32  id_pc + 4, used by decode for branch offset and JAL link.
- id_valid  output  1  id_instr is a real fetched instruction, not a bubble.
- fetch_count  output  32  number of valid instructions delivered to IF/ID since reset.

## Operation
- No branch delay slot. An instruction fetched in the cycle a redirect is asserted is wrong-path and is squashed.
- Priority each cycle, highest first: reset, redirect_en, stall, normal.
- reset:
  - pc <= RESET_PC
  - id_instr <= 0, id_pc <= 0, id_pc_plus4 <= 0, id_valid <= 0
  - fetch_count <= 0
- redirect_en=1, regardless of stall:
  - pc <= {redirect_target[31:2], 2'b00}
  - IF/ID loads a bubble: id_instr <= 0, id_valid <= 0
  - id_pc and id_pc_plus4 hold their previous values
  - fetch_count unchanged
- stall=1, redirect_en=0:
  - pc holds; all id_* hold; fetch_count holds.
- Normal (neither asserted):
  - pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
  - id_instr <= imem_rdata, id_pc <= pc, id_pc_plus4 <= pc + 4 (same wrap), id_valid <= 1
  - fetch_count <= fetch_count + 1, wrapping at 2^32.
- A misaligned RESET_PC is used as given; only redirect targets are force-aligned.

## Timing
- One-cycle latency: the word at address A, fetched in cycle n, appears on id_instr after the edge ending cycle n.
- imem_addr = pc, combinational; the block has no other combinational input-to-output paths.
- Redirect asserted in cycle n:
  - pc = target in cycle n+1.
  - id_valid = 0 in cycle n+1.
  - The target instruction appears on id_* in cycle n+2.
- Stall asserted for k consecutive cycles freezes all outputs for k cycles. Fetch resumes with the same pc afterwards, so no instruction is lost or duplicated.
- Reset asserted mid-stream: all state takes reset values on the next edge, overriding stall/redirect. In the first cycle after reset deasserts, imem_addr = RESET_PC and id_valid = 0. The first valid id_instr appears one cycle later.

## Test plan
- Reset then free-run, imem returning word = address: after reset, pc=32'h3000, id_valid=0. Next edges give id_instr/id_pc = 3000,3004,3008. id_pc_plus4 = id_pc+4; fetch_count increments 1,2,3.
- Stall for 3 cycles while pc=32'h3008: pc, id_instr(3004), id_valid and fetch_count frozen for exactly 3 cycles. Then id_instr=3008 with no gap and no duplicate.
- Redirect to 32'h3041 while pc=32'h3010: next cycle pc=32'h3040, id_valid=0, id_instr=0, fetch_count unchanged. Following cycle id_instr=3040, id_pc=32'h3040.
- Simultaneous stall=1 and redirect_en=1, target 32'h3100: redirect wins. pc=32'h3100, bubble in IF/ID.
- Wrap: redirect to 32'hFFFF_FFFC, then run. pc=0 next, id_pc=FFFF_FFFC, id_pc_plus4=0.
- Reset asserted during a stall with pc=32'h3020: next cycle pc=32'h3000, id_valid=0, fetch_count=0.
